// File: rtl/line_dma_pkg.sv
// rtl/line_dma_pkg.sv - shared constants and state encoding for the line copy engine
// Line geometry defaults are shared with the line-buffer writer.
package line_dma_pkg;

   localparam int LINE_WORDS_DEF = 160;
   localparam int HALF_WORDS_DEF = 512;
   localparam int ADDR_W_DEF     = 10;

   localparam int   WORD_BYTES = 8;
   localparam logic VM_READ    = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RD_REQ  = 3'd1,
      ST_RD_WAIT = 3'd2,
      ST_WR      = 3'd3,
      ST_FINISH  = 3'd4
   } state_e;

endpackage

// File: rtl/word_fifo2.sv
// rtl/word_fifo2.sv - two-entry 64-bit word FIFO with synchronous flush
// Push is dropped when full and pop when empty; flush overrides both.
module word_fifo2 (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        push,
   input  logic [63:0] push_data,
   input  logic        pop,
   output logic [63:0] pop_data,
   output logic        full,
   output logic        empty
);

   logic [63:0] mem_q [2];
   logic [63:0] mem_d [2];
   logic        wr_ptr_q, wr_ptr_d;
   logic        rd_ptr_q, rd_ptr_d;
   logic [1:0]  count_q, count_d;
   logic        do_push, do_pop;

   assign full     = (count_q == 2'd2);
   assign empty    = (count_q == 2'd0);
   assign pop_data = mem_q[rd_ptr_q];
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
         count_d  = 2'd0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
         end
         if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
         end
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/line_dma.sv
// rtl/line_dma.sv - copies one line-buffer line into SDRAM over an Avalon-MM write master
// LINE_DMA_PREFETCH_EN overlaps the next read with the current write through word_fifo2.
module line_dma
   import line_dma_pkg::*;
#(
   parameter int LINE_WORDS = LINE_WORDS_DEF,
   parameter int HALF_WORDS = HALF_WORDS_DEF,
   parameter int ADDR_W     = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic              src_half,
   input  logic [31:0]       dst_addr,
   input  logic              clear_count,
   output logic              busy,
   output logic              done,
   output logic              aborted,
   output logic [15:0]       lines_done,
   output logic              vm_bus_enable,
   output logic              vm_rw,
   output logic [ADDR_W-1:0] vm_address,
   input  logic              vm_acknowledge,
   input  logic [63:0]       vm_read_data,
   output logic [31:0]       av_address,
   output logic              av_write,
   output logic [63:0]       av_writedata,
   output logic [7:0]        av_byteenable,
   input  logic              av_waitrequest
);

   localparam logic [ADDR_W-1:0] HALF_BASE = ADDR_W'(HALF_WORDS);
   localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(LINE_WORDS - 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [31:0]       dst_q, dst_d;
   logic              abort_pend_q, abort_pend_d;
   logic              aborted_q, aborted_d;
   logic [15:0]       lines_done_q, lines_done_d;
   logic              abort_now;

   assign abort_now     = abort_pend_q | abort;
   assign vm_rw         = VM_READ;
   assign av_byteenable = 8'hFF;
   assign busy          = (state_q != ST_IDLE) && (state_q != ST_FINISH);
   assign done          = (state_q == ST_FINISH);
   assign aborted       = aborted_q;
   assign lines_done    = lines_done_q;

`ifdef LINE_DMA_PREFETCH_EN

   localparam logic [ADDR_W:0] LINE_CNT = (ADDR_W+1)'(LINE_WORDS);

   logic [ADDR_W:0]   rd_idx_q, rd_idx_d;
   logic [ADDR_W-1:0] wr_idx_q, wr_idx_d;
   logic              rd_busy_q, rd_busy_d;
   logic              fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
   logic [63:0]       fifo_rdata;
   logic              accept, ack_now;

   word_fifo2 u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (fifo_flush),
      .push      (fifo_push),
      .push_data (vm_read_data),
      .pop       (fifo_pop),
      .pop_data  (fifo_rdata),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign vm_bus_enable = rd_busy_q;
   assign vm_address    = rd_busy_q ? base_q + ADDR_W'(rd_idx_q) : '0;
   assign av_write      = (state_q == ST_WR) && !fifo_empty;
   assign av_address    = av_write ? dst_q + 32'(wr_idx_q) * 32'(WORD_BYTES) : '0;
   assign av_writedata  = av_write ? fifo_rdata : '0;
   assign accept        = av_write && !av_waitrequest;
   assign ack_now       = rd_busy_q && vm_acknowledge;

   // ST_WR is the single running state: reader and writer advance independently in it.
   always_comb begin
      state_d      = state_q;
      base_d       = base_q;
      dst_d        = dst_q;
      abort_pend_d = abort_pend_q;
      aborted_d    = aborted_q;
      lines_done_d = lines_done_q;
      rd_idx_d     = rd_idx_q;
      wr_idx_d     = wr_idx_q;
      rd_busy_d    = rd_busy_q;
      fifo_push    = 1'b0;
      fifo_pop     = 1'b0;
      fifo_flush   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               base_d     = src_half ? HALF_BASE : '0;
               dst_d      = dst_addr & 32'hFFFF_FFF8;
               rd_idx_d   = '0;
               wr_idx_d   = '0;
               aborted_d  = 1'b0;
               fifo_flush = 1'b1;
               state_d    = ST_WR;
            end
         end
         ST_WR: begin
            abort_pend_d = abort_now;
            if (ack_now) begin
               rd_busy_d = 1'b0;
               rd_idx_d  = rd_idx_q + (ADDR_W+1)'(1);
               fifo_push = !abort_now;
            end else if (!rd_busy_q && !abort_now && (rd_idx_q < LINE_CNT) && !fifo_full) begin
               rd_busy_d = 1'b1;
            end
            if (accept) begin
               fifo_pop = 1'b1;
               wr_idx_d = wr_idx_q + ADDR_W'(1);
            end
            if (accept && (wr_idx_q == LAST_IDX)) begin
               state_d = ST_FINISH;
            end else if (abort_now && (!av_write || accept) && (!rd_busy_q || ack_now)) begin
               state_d = ST_FINISH;
            end
         end
         ST_FINISH: begin
            if (abort_pend_q) aborted_d = 1'b1;
            else              lines_done_d = lines_done_q + 16'd1;
            abort_pend_d = 1'b0;
            fifo_flush   = 1'b1;
            state_d      = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (clear_count) lines_done_d = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         base_q       <= '0;
         dst_q        <= '0;
         abort_pend_q <= 1'b0;
         aborted_q    <= 1'b0;
         lines_done_q <= '0;
         rd_idx_q     <= '0;
         wr_idx_q     <= '0;
         rd_busy_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         base_q       <= base_d;
         dst_q        <= dst_d;
         abort_pend_q <= abort_pend_d;
         aborted_q    <= aborted_d;
         lines_done_q <= lines_done_d;
         rd_idx_q     <= rd_idx_d;
         wr_idx_q     <= wr_idx_d;
         rd_busy_q    <= rd_busy_d;
      end
   end

`else

   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [63:0]       data_q, data_d;

   // Enable stays high through the ack cycle and drops in WR, so two acks are never back to back.
   assign vm_bus_enable = (state_q == ST_RD_REQ) || (state_q == ST_RD_WAIT);
   assign vm_address    = vm_bus_enable ? base_q + idx_q : '0;
   assign av_write      = (state_q == ST_WR);
   assign av_address    = av_write ? dst_q + 32'(idx_q) * 32'(WORD_BYTES) : '0;
   assign av_writedata  = av_write ? data_q : '0;

   always_comb begin
      state_d      = state_q;
      base_d       = base_q;
      dst_d        = dst_q;
      abort_pend_d = abort_pend_q;
      aborted_d    = aborted_q;
      lines_done_d = lines_done_q;
      idx_d        = idx_q;
      data_d       = data_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               base_d    = src_half ? HALF_BASE : '0;
               dst_d     = dst_addr & 32'hFFFF_FFF8;
               idx_d     = '0;
               aborted_d = 1'b0;
               state_d   = ST_RD_REQ;
            end
         end
         ST_RD_REQ: begin
            abort_pend_d = abort_now;
            state_d      = ST_RD_WAIT;
         end
         ST_RD_WAIT: begin
            abort_pend_d = abort_now;
            if (vm_acknowledge) begin
               data_d  = vm_read_data;
               state_d = abort_now ? ST_FINISH : ST_WR;
            end
         end
         ST_WR: begin
            abort_pend_d = abort_now;
            if (!av_waitrequest) begin
               if ((idx_q == LAST_IDX) || abort_now) begin
                  state_d = ST_FINISH;
               end else begin
                  idx_d   = idx_q + ADDR_W'(1);
                  state_d = ST_RD_REQ;
               end
            end
         end
         ST_FINISH: begin
            if (abort_pend_q) aborted_d = 1'b1;
            else              lines_done_d = lines_done_q + 16'd1;
            abort_pend_d = 1'b0;
            state_d      = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (clear_count) lines_done_d = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         base_q       <= '0;
         dst_q        <= '0;
         abort_pend_q <= 1'b0;
         aborted_q    <= 1'b0;
         lines_done_q <= '0;
         idx_q        <= '0;
         data_q       <= '0;
      end else begin
         state_q      <= state_d;
         base_q       <= base_d;
         dst_q        <= dst_d;
         abort_pend_q <= abort_pend_d;
         aborted_q    <= aborted_d;
         lines_done_q <= lines_done_d;
         idx_q        <= idx_d;
         data_q       <= data_d;
      end
   end

`endif

endmodule

// File: tb/tb_line_dma.sv
// tb/tb_line_dma.sv - directed self-checking bench for line_dma
module tb_line_dma;

   localparam int LW = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        src_half = 1'b0;
   logic [31:0] dst_addr = '0;
   logic        clear_count = 1'b0;
   logic        busy, done, aborted;
   logic [15:0] lines_done;
   logic        vm_bus_enable, vm_rw;
   logic [9:0]  vm_address;
   logic        vm_acknowledge;
   logic [63:0] vm_read_data;
   logic [31:0] av_address;
   logic        av_write;
   logic [63:0] av_writedata;
   logic [7:0]  av_byteenable;
   logic        av_waitrequest;

   int n_checks = 0;
   int n_fail   = 0;

   always #10 clk = ~clk;

   line_dma #(.LINE_WORDS(LW), .HALF_WORDS(512), .ADDR_W(10)) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .abort          (abort),
      .src_half       (src_half),
      .dst_addr       (dst_addr),
      .clear_count    (clear_count),
      .busy           (busy),
      .done           (done),
      .aborted        (aborted),
      .lines_done     (lines_done),
      .vm_bus_enable  (vm_bus_enable),
      .vm_rw          (vm_rw),
      .vm_address     (vm_address),
      .vm_acknowledge (vm_acknowledge),
      .vm_read_data   (vm_read_data),
      .av_address     (av_address),
      .av_write       (av_write),
      .av_writedata   (av_writedata),
      .av_byteenable  (av_byteenable),
      .av_waitrequest (av_waitrequest)
   );

   // Line-buffer slave: samples enable, acks two edges later, ignores enable in its ack cycle.
   logic       pend;
   logic [9:0] pend_addr;

   function automatic logic [63:0] vm_word(input logic [9:0] a);
      if (a >= 10'd512) return 64'hBEEF_0000_0000_0000 | 64'(a - 10'd512);
      return 64'(a);
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         vm_acknowledge <= 1'b0;
         vm_read_data   <= '0;
         pend           <= 1'b0;
         pend_addr      <= '0;
      end else if (vm_acknowledge) begin
         vm_acknowledge <= 1'b0;
      end else if (pend) begin
         vm_acknowledge <= 1'b1;
         vm_read_data   <= vm_word(pend_addr);
         pend           <= 1'b0;
      end else if (vm_bus_enable) begin
         pend      <= 1'b1;
         pend_addr <= vm_address;
      end
   end

   logic        stall_en = 1'b0;
   logic [31:0] stall_addr = '0;
   int          stall_len = 0;
   int          stall_cnt;
   assign av_waitrequest = stall_en && av_write && (av_address == stall_addr) && (stall_cnt < stall_len);

   logic        log_clr = 1'b0;
   int          rd_count, wr_count, done_count, unstable;
   logic [9:0]  rd_log [16];
   logic [31:0] wr_addr_log [16];
   logic [63:0] wr_data_log [16];
   logic        prev_stall;
   logic [31:0] prev_addr;
   logic [63:0] prev_data;

   always @(posedge clk) begin
      if (log_clr) begin
         rd_count   <= 0;
         wr_count   <= 0;
         done_count <= 0;
         stall_cnt  <= 0;
         unstable   <= 0;
         prev_stall <= 1'b0;
      end else begin
         if (vm_bus_enable && !vm_acknowledge && !pend) begin
            if (rd_count < 16) rd_log[rd_count] <= vm_address;
            rd_count <= rd_count + 1;
         end
         if (av_write && !av_waitrequest) begin
            if (wr_count < 16) begin
               wr_addr_log[wr_count] <= av_address;
               wr_data_log[wr_count] <= av_writedata;
            end
            wr_count <= wr_count + 1;
         end
         if (done) done_count <= done_count + 1;
         if (av_write && av_waitrequest) stall_cnt <= stall_cnt + 1;
         if (prev_stall && (!av_write || av_address != prev_addr || av_writedata != prev_data))
            unstable <= unstable + 1;
         prev_stall <= av_write && av_waitrequest;
         prev_addr  <= av_address;
         prev_data  <= av_writedata;
      end
   end

   task automatic clear_logs();
      @(negedge clk); log_clr = 1'b1;
      @(negedge clk); log_clr = 1'b0;
   endtask

   task automatic run_start(input logic half, input logic [31:0] dst);
      @(negedge clk);
      src_half = half; dst_addr = dst; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(output int n, output bit ok);
      n = 0; ok = 1'b0;
      while (!ok && n < 400) begin
         if (done) ok = 1'b1;
         else begin @(negedge clk); n++; end
      end
   endtask

   task automatic test_reset();
      #25;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
      n_checks++; if (aborted !== 1'b0) begin n_fail++; $display("FAIL reset_aborted: got %b want 0", aborted); end
      n_checks++; if (lines_done !== 16'h0) begin n_fail++; $display("FAIL reset_lines: got %h want 0000", lines_done); end
      n_checks++; if (vm_rw !== 1'b1) begin n_fail++; $display("FAIL reset_vm_rw: got %b want 1", vm_rw); end
      n_checks++; if (av_byteenable !== 8'hFF) begin n_fail++; $display("FAIL reset_be: got %h want ff", av_byteenable); end
      n_checks++; if (vm_bus_enable !== 1'b0 || av_write !== 1'b0) begin n_fail++; $display("FAIL reset_strobes: got en=%b wr=%b want 0 0", vm_bus_enable, av_write); end
      n_checks++; if (vm_address !== 10'h0 || av_address !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h %h want 0 0", vm_address, av_address); end
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_basic_copy();
      logic [31:0] exp_addr [4];
      int n; bit ok;
      exp_addr = '{32'h2000_0000, 32'h2000_0008, 32'h2000_0010, 32'h2000_0018};
      stall_en = 1'b0;
      clear_logs();
      run_start(1'b0, 32'h2000_0005);
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b want 1", busy); end
      wait_done(n, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_timeout: done not seen in %0d cycles", n); end
`ifndef LINE_DMA_PREFETCH_EN
      n_checks++; if (n != 16) begin n_fail++; $display("FAIL basic_latency: got %0d clk want 16", n); end
`endif
      @(negedge clk); @(negedge clk);
      n_checks++; if (wr_count != 4) begin n_fail++; $display("FAIL basic_wr_count: got %0d want 4", wr_count); end
      for (int i = 0; i < 4; i++) begin
         n_checks++; if (wr_addr_log[i] !== exp_addr[i]) begin n_fail++; $display("FAIL basic_addr%0d: got %h want %h", i, wr_addr_log[i], exp_addr[i]); end
         n_checks++; if (wr_data_log[i] !== 64'(i)) begin n_fail++; $display("FAIL basic_data%0d: got %h want %h", i, wr_data_log[i], 64'(i)); end
      end
      n_checks++; if (done_count != 1) begin n_fail++; $display("FAIL basic_done_pulses: got %0d want 1", done_count); end
      n_checks++; if (lines_done !== 16'd1) begin n_fail++; $display("FAIL basic_lines: got %0d want 1", lines_done); end
      n_checks++; if (aborted !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle: got aborted=%b busy=%b want 0 0", aborted, busy); end
   endtask

   task automatic test_second_half();
      logic [63:0] exp_data [4];
      int n; bit ok;
      exp_data = '{64'hBEEF_0000_0000_0000, 64'hBEEF_0000_0000_0001, 64'hBEEF_0000_0000_0002, 64'hBEEF_0000_0000_0003};
      stall_en = 1'b1; stall_addr = 32'h3000_0050; stall_len = 3;
      clear_logs();
      run_start(1'b1, 32'h3000_0040);
      wait_done(n, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL half_timeout: done not seen in %0d cycles", n); end
      @(negedge clk); @(negedge clk);
      stall_en = 1'b0;
      n_checks++; if (rd_count != 4) begin n_fail++; $display("FAIL half_rd_count: got %0d want 4", rd_count); end
      for (int i = 0; i < 4; i++) begin
         n_checks++; if (rd_log[i] !== 10'(512 + i)) begin n_fail++; $display("FAIL half_vm_addr%0d: got %0d want %0d", i, rd_log[i], 512 + i); end
         n_checks++; if (wr_data_log[i] !== exp_data[i]) begin n_fail++; $display("FAIL half_data%0d: got %h want %h", i, wr_data_log[i], exp_data[i]); end
      end
      n_checks++; if (wr_count != 4) begin n_fail++; $display("FAIL half_wr_count: got %0d want 4", wr_count); end
      n_checks++; if (wr_addr_log[2] !== 32'h3000_0050) begin n_fail++; $display("FAIL half_addr2: got %h want 30000050", wr_addr_log[2]); end
      n_checks++; if (stall_cnt != 3) begin n_fail++; $display("FAIL half_stall_cycles: got %0d want 3", stall_cnt); end
      n_checks++; if (unstable != 0) begin n_fail++; $display("FAIL half_stable: got %0d changes want 0", unstable); end
      n_checks++; if (lines_done !== 16'd2) begin n_fail++; $display("FAIL half_lines: got %0d want 2", lines_done); end
   endtask

   task automatic test_abort_read();
      int n, k; bit ok;
      stall_en = 1'b0;
      clear_logs();
      run_start(1'b0, 32'h4000_0000);
      k = 0;
      while (!(vm_bus_enable && vm_address == 10'd2) && k < 100) begin @(negedge clk); k++; end
      n_checks++; if (k >= 100) begin n_fail++; $display("FAIL abort_rd_find: read of idx 2 not seen in %0d cycles", k); end
      @(negedge clk); abort = 1'b1;
      @(negedge clk); abort = 1'b0;
      wait_done(n, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL abort_rd_timeout: done not seen in %0d cycles", n); end
      @(negedge clk); @(negedge clk);
      n_checks++; if (wr_count != 2) begin n_fail++; $display("FAIL abort_rd_writes: got %0d want 2", wr_count); end
      n_checks++; if (wr_addr_log[1] !== 32'h4000_0008) begin n_fail++; $display("FAIL abort_rd_addr1: got %h want 40000008", wr_addr_log[1]); end
      n_checks++; if (rd_count != 3) begin n_fail++; $display("FAIL abort_rd_reads: got %0d want 3", rd_count); end
      n_checks++; if (done_count != 1) begin n_fail++; $display("FAIL abort_rd_done: got %0d want 1", done_count); end
      n_checks++; if (aborted !== 1'b1) begin n_fail++; $display("FAIL abort_rd_flag: got %b want 1", aborted); end
      n_checks++; if (lines_done !== 16'd2) begin n_fail++; $display("FAIL abort_rd_lines: got %0d want 2", lines_done); end
   endtask

   task automatic test_abort_write();
      int n, k, rd_before; bit ok;
      stall_en = 1'b1; stall_addr = 32'h5000_0008; stall_len = 3;
      clear_logs();
      run_start(1'b0, 32'h5000_0000);
      k = 0;
      while (!av_waitrequest && k < 100) begin @(negedge clk); k++; end
      n_checks++; if (k >= 100) begin n_fail++; $display("FAIL abort_wr_find: stall not seen in %0d cycles", k); end
      rd_before = rd_count;
      abort = 1'b1;
      @(negedge clk); abort = 1'b0;
      wait_done(n, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL abort_wr_timeout: done not seen in %0d cycles", n); end
      @(negedge clk); @(negedge clk);
      stall_en = 1'b0;
      n_checks++; if (wr_count != 2) begin n_fail++; $display("FAIL abort_wr_writes: got %0d want 2", wr_count); end
      n_checks++; if (wr_addr_log[1] !== 32'h5000_0008) begin n_fail++; $display("FAIL abort_wr_addr1: got %h want 50000008", wr_addr_log[1]); end
      n_checks++; if (rd_count != rd_before) begin n_fail++; $display("FAIL abort_wr_reads: got %0d want %0d", rd_count, rd_before); end
      n_checks++; if (done_count != 1) begin n_fail++; $display("FAIL abort_wr_done: got %0d want 1", done_count); end
      n_checks++; if (aborted !== 1'b1) begin n_fail++; $display("FAIL abort_wr_flag: got %b want 1", aborted); end
   endtask

   task automatic test_ignored_start();
      int n; bit ok;
      stall_en = 1'b0;
      clear_logs();
      run_start(1'b0, 32'h6000_0000);
      n_checks++; if (aborted !== 1'b0) begin n_fail++; $display("FAIL restart_aborted_clear: got %b want 0", aborted); end
      @(negedge clk); @(negedge clk);
      src_half = 1'b1; dst_addr = 32'h7000_0000; start = 1'b1;
      @(negedge clk); start = 1'b0;
      wait_done(n, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL busy_start_timeout: done not seen in %0d cycles", n); end
      @(negedge clk); @(negedge clk);
      n_checks++; if (wr_count != 4) begin n_fail++; $display("FAIL busy_start_writes: got %0d want 4", wr_count); end
      n_checks++; if (wr_addr_log[3] !== 32'h6000_0018) begin n_fail++; $display("FAIL busy_start_addr3: got %h want 60000018", wr_addr_log[3]); end
      n_checks++; if (rd_log[3] !== 10'd3) begin n_fail++; $display("FAIL busy_start_vm3: got %0d want 3", rd_log[3]); end
      n_checks++; if (done_count != 1) begin n_fail++; $display("FAIL busy_start_done: got %0d want 1", done_count); end
      n_checks++; if (lines_done !== 16'd3) begin n_fail++; $display("FAIL busy_start_lines: got %0d want 3", lines_done); end
   endtask

   task automatic test_reset_mid_copy();
      int k;
      stall_en = 1'b0;
      clear_logs();
      run_start(1'b0, 32'h8000_0000);
      k = 0;
      while (!av_write && k < 100) begin @(negedge clk); k++; end
      n_checks++; if (k >= 100) begin n_fail++; $display("FAIL rstmid_find: write not seen in %0d cycles", k); end
      n_checks++; if (lines_done !== 16'd3) begin n_fail++; $display("FAIL rstmid_pre_lines: got %0d want 3", lines_done); end
      #3 rst = 1'b1;
      #1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
      n_checks++; if (av_write !== 1'b0) begin n_fail++; $display("FAIL rstmid_av_write: got %b want 0", av_write); end
      n_checks++; if (vm_bus_enable !== 1'b0) begin n_fail++; $display("FAIL rstmid_vm_en: got %b want 0", vm_bus_enable); end
      n_checks++; if (lines_done !== 16'd0) begin n_fail++; $display("FAIL rstmid_lines: got %0d want 0", lines_done); end
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_counter_wrap();
      int n; bit ok;
      stall_en = 1'b0;
      clear_logs();
      @(negedge clk);
      force dut.lines_done_q = 16'hFFFF;
      @(negedge clk);
      release dut.lines_done_q;
      run_start(1'b0, 32'h9000_0000);
      wait_done(n, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL wrap_timeout: done not seen in %0d cycles", n); end
      @(negedge clk);
      n_checks++; if (lines_done !== 16'h0000) begin n_fail++; $display("FAIL wrap_lines: got %h want 0000", lines_done); end
   endtask

   task automatic test_clear_on_finish();
      int n; bit ok;
      stall_en = 1'b0;
      clear_logs();
      run_start(1'b0, 32'hA000_0000);
      wait_done(n, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL clear_timeout: done not seen in %0d cycles", n); end
      clear_count = 1'b1;
      @(negedge clk); clear_count = 1'b0;
      n_checks++; if (lines_done !== 16'd0) begin n_fail++; $display("FAIL clear_on_finish: got %0d want 0", lines_done); end
      run_start(1'b0, 32'hA000_0100);
      wait_done(n, ok);
      @(negedge clk);
      n_checks++; if (lines_done !== 16'd1) begin n_fail++; $display("FAIL clear_then_count: got %0d want 1", lines_done); end
   endtask

   initial begin
      test_reset();
      test_basic_copy();
      test_second_half();
      test_abort_read();
      test_abort_write();
      test_ignored_start();
      test_reset_mid_copy();
      test_counter_wrap();
      test_clear_on_finish();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
